// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared widths, limits and result types for the FP adder datapath
package fp_add_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 25;
  localparam int FRAC_W = 23;
  localparam int IDX_W  = 5;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_word_t;

endpackage

// File: rtl/FindFirstOne.sv
// rtl/FindFirstOne.sv - leading-one detector returning the index of the highest set bit
module FindFirstOne #(
  parameter int WIDTH = 25,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             nz
);

  // Scan upward so the last set bit seen, the most significant one, wins.
  always_comb begin
    idx = '0;
    nz  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = i[IDX_W-1:0];
        nz  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_shifter.sv
// rtl/norm_shifter.sv - mantissa normalization shift, exponent adjust and range clamp
module norm_shifter
  import fp_add_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] mant,
  input  logic [IDX_W-1:0]  idx,
  input  logic              nz,
  output fp_word_t          word,
  output fp_flags_t         flags
);

  logic [IDX_W-1:0]  shift_amt;
  logic [FRAC_W-1:0] frac_sh;
  logic signed [9:0] e;

  // Priority: special exponent, exact zero, then shift and clamp into range.
  // The fraction is built from bits below the leading one only, so the hidden
  // bit falls off the top of the 23-bit result by construction.
  always_comb begin
    word      = '0;
    flags     = '0;
    shift_amt = '0;
    frac_sh   = mant[FRAC_W-1:0];
    e         = $signed({2'b00, exp});

    if (exp == EXP_MAX) begin
      word.sign = sign;
      word.exp  = exp;
      word.frac = mant[FRAC_W-1:0];
    end else if (!nz) begin
      word = '0;
    end else begin
      if (idx == 5'd24) begin
        frac_sh       = mant[FRAC_W:1];
        e             = $signed({2'b00, exp}) + 10'sd1;
        flags.inexact = mant[0];
      end else if (idx == 5'd23) begin
        frac_sh = mant[FRAC_W-1:0];
      end else begin
        shift_amt = 5'd23 - idx;
        frac_sh   = mant[FRAC_W-1:0] << shift_amt;
        e         = $signed({2'b00, exp}) - $signed({5'b00000, shift_amt});
      end

      word.sign = sign;
      if (e >= 10'sd255) begin
        word.exp       = EXP_MAX;
        word.frac      = '0;
        flags.overflow = 1'b1;
      end else if (e <= 10'sd0) begin
        word.exp        = '0;
        word.frac       = '0;
        flags.underflow = 1'b1;
      end else begin
        word.exp  = e[EXP_W-1:0];
        word.frac = frac_sh;
      end
    end
  end

endmodule

// File: rtl/fp_normalize_stage.sv
// rtl/fp_normalize_stage.sv - two-stage elastic post-add normalization pipeline
module fp_normalize_stage
  import fp_add_pkg::*;
#(
  parameter int MANT_W = 25,
  parameter int EXP_W  = 8,
  parameter int IDX_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [22:0]       out_frac,
  output logic [2:0]        out_flags
);

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q,  s1_sign_d;
  logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
  logic [MANT_W-1:0] s1_mant_q,  s1_mant_d;
  logic [IDX_W-1:0]  s1_idx_q,   s1_idx_d;
  logic              s1_nz_q,    s1_nz_d;

  logic              s2_valid_q, s2_valid_d;
  fp_word_t          s2_word_q,  s2_word_d;
  fp_flags_t         s2_flags_q, s2_flags_d;

  logic              s1_advance;
  logic              s2_advance;
  logic [IDX_W-1:0]  ffo_idx;
  logic              ffo_nz;
  fp_word_t          norm_word;
  fp_flags_t         norm_flags;

  FindFirstOne #(
    .WIDTH (MANT_W),
    .IDX_W (IDX_W)
  ) u_ffo (
    .vec (in_mant),
    .idx (ffo_idx),
    .nz  (ffo_nz)
  );

  norm_shifter u_norm (
    .sign  (s1_sign_q),
    .exp   (s1_exp_q),
    .mant  (s1_mant_q),
    .idx   (s1_idx_q),
    .nz    (s1_nz_q),
    .word  (norm_word),
    .flags (norm_flags)
  );

  // Handshake: a stage moves when it is empty or its successor is moving.
  always_comb begin
    s2_advance = ~s2_valid_q | out_ready;
    s1_advance = ~s1_valid_q | s2_advance;
    in_ready   = ~s1_valid_q | s1_advance;
  end

  // Next-state for both stages; data registers only load on a real item.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_idx_d   = s1_idx_q;
    s1_nz_d    = s1_nz_q;
    s2_valid_d = s2_valid_q;
    s2_word_d  = s2_word_q;
    s2_flags_d = s2_flags_q;

    if (s1_advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_sign;
        s1_exp_d  = in_exp;
        s1_mant_d = in_mant;
        s1_idx_d  = ffo_idx;
        s1_nz_d   = ffo_nz;
      end
    end

    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_word_d  = norm_word;
        s2_flags_d = norm_flags;
      end
    end
  end

  // Pipeline registers; reset drops every in-flight item.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_idx_q   <= '0;
      s1_nz_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_word_q  <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_idx_q   <= s1_idx_d;
      s1_nz_q    <= s1_nz_d;
      s2_valid_q <= s2_valid_d;
      s2_word_q  <= s2_word_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  // Stage 2 registers drive the outputs directly.
  always_comb begin
    out_valid = s2_valid_q;
    out_sign  = s2_word_q.sign;
    out_exp   = s2_word_q.exp;
    out_frac  = s2_word_q.frac;
    out_flags = s2_flags_q;
  end

endmodule

// File: tb/tb_fp_normalize_stage.sv
// tb/tb_fp_normalize_stage.sv - scoreboard bench for fp_normalize_stage
module tb_fp_normalize_stage;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic [2:0]  flags;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic [2:0]  out_flags;

  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   pop_cyc[$];

  fp_normalize_stage dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_flags (out_flags)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  function automatic exp_t mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                              input logic [2:0] fl);
    exp_t r;
    r.sign = s; r.exp = e; r.frac = f; r.flags = fl;
    return r;
  endfunction

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Caller must be at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input exp_t x);
    int   waited = 0;
    logic done = 1'b0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(x);
        done = 1'b1;
      end else if (++waited > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    sync();
    in_valid = 1'b0;
  endtask

  // Monitor: pop on every output transfer, hold-check against the head while stalled.
  always @(negedge clock) begin
    exp_t got;
    exp_t want;
    if (!reset && out_valid) begin
      got = {out_sign, out_exp, out_frac, out_flags};
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {29'd0, got}, 64'hDEAD);
        end else begin
          want = sb.pop_front();
          check("result", {29'd0, got}, {29'd0, want});
          pop_cyc.push_back(cyc);
        end
      end else if (sb.size() != 0) begin
        check("stall_hold", {29'd0, got}, {29'd0, sb[0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sign",  {63'd0, out_sign},  64'd0);
    check("rst_out_exp",   {56'd0, out_exp},   64'd0);
    check("rst_out_frac",  {41'd0, out_frac},  64'd0);
    check("rst_out_flags", {61'd0, out_flags}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);

    // Carry-out with a dropped LSB, plus two-cycle latency.
    sync();
    send(1'b0, 8'h80, 25'h1000001, mk(1'b0, 8'h81, 23'h000000, 3'b001));
    @(negedge clock);
    check("latency_cycle1", {63'd0, out_valid}, 64'd0);
    @(negedge clock);
    check("latency_cycle2", {63'd0, out_valid}, 64'd1);

    sync();
    send(1'b0, 8'h7F, 25'h0800000, mk(1'b0, 8'h7F, 23'h000000, 3'b000));
    send(1'b0, 8'h80, 25'h0000001, mk(1'b0, 8'h69, 23'h000000, 3'b000));
    send(1'b0, 8'h05, 25'h0000100, mk(1'b0, 8'h00, 23'h000000, 3'b010));
    send(1'b0, 8'hFE, 25'h1800000, mk(1'b0, 8'hFF, 23'h000000, 3'b100));
    send(1'b1, 8'h40, 25'h0000000, mk(1'b0, 8'h00, 23'h000000, 3'b000));
    send(1'b1, 8'hFF, 25'h0123456, mk(1'b1, 8'hFF, 23'h123456, 3'b000));
    send(1'b0, 8'h10, 25'h0C00000, mk(1'b0, 8'h10, 23'h400000, 3'b000));
    send(1'b1, 8'h10, 25'h1C00001, mk(1'b1, 8'h11, 23'h600000, 3'b001));
    send(1'b0, 8'h30, 25'h0000003, mk(1'b0, 8'h1A, 23'h400000, 3'b000));
    send(1'b1, 8'h01, 25'h0400000, mk(1'b1, 8'h00, 23'h000000, 3'b010));
    send(1'b0, 8'h02, 25'h0400000, mk(1'b0, 8'h01, 23'h000000, 3'b000));
    send(1'b0, 8'hFD, 25'h1000000, mk(1'b0, 8'hFE, 23'h000000, 3'b000));
    send(1'b1, 8'hFE, 25'h1000001, mk(1'b1, 8'hFF, 23'h000000, 3'b101));
    repeat (4) sync();

    // Back-to-back burst of eight with the sink always ready.
    base = pop_cyc.size();
    for (int i = 0; i < 8; i++)
      send(1'b0, 8'h7F, 25'h0800000, mk(1'b0, 8'h7F, 23'h000000, 3'b000));
    repeat (4) sync();
    check("burst_count", pop_cyc.size() - base, 64'd8);
    if (pop_cyc.size() - base == 8)
      check("burst_span", pop_cyc[base+7] - pop_cyc[base], 64'd7);

    // Stall: sink blocked, pipe fills, then drains in order.
    out_ready = 1'b0;
    send(1'b0, 8'h10, 25'h0C00000, mk(1'b0, 8'h10, 23'h400000, 3'b000));
    send(1'b0, 8'h30, 25'h0000003, mk(1'b0, 8'h1A, 23'h400000, 3'b000));
    fork
      send(1'b1, 8'hFF, 25'h0123456, mk(1'b1, 8'hFF, 23'h123456, 3'b000));
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        sync();
        out_ready = 1'b1;
      end
    join
    repeat (5) sync();
    check("drain_empty", sb.size(), 64'd0);

    // Reset with two items in flight.
    out_ready = 1'b0;
    send(1'b0, 8'h7F, 25'h0800000, mk(1'b0, 8'h7F, 23'h000000, 3'b000));
    send(1'b0, 8'h80, 25'h0000001, mk(1'b0, 8'h69, 23'h000000, 3'b000));
    reset = 1'b1;
    sb.delete();
    sync();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_rst_in_ready",  {63'd0, in_ready},  64'd1);
    sync();
    out_ready = 1'b1;
    repeat (6) sync();
    send(1'b0, 8'h10, 25'h0C00000, mk(1'b0, 8'h10, 23'h400000, 3'b000));
    repeat (5) sync();
    check("final_empty", sb.size(), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
